// File: rtl/chase_supervisor.sv
// chase_supervisor: frame-paced arm/acquire/chase/search/halt sequencer between the
// control loop and motor_out, with per-frame speed/turn ramping and a camera watchdog.
module chase_supervisor #(
   parameter int unsigned MIN_RAD       = 10,
   parameter int unsigned REACQ_FRAMES  = 3,
   parameter int unsigned LOST_FRAMES   = 8,
   parameter int unsigned SEARCH_FRAMES = 90,
   parameter int          SEARCH_TURN   = 60,
   parameter int unsigned RAMP_STEP     = 16,
   parameter int unsigned TIMEOUT_CYC   = 4333333
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              frame_done_in,
   input  logic              enable_in,
   input  logic              pause_in,
   input  logic [6:0]        cur_rad_in,
   input  logic signed [8:0] speed_in,
   input  logic signed [8:0] turn_in,
   output logic signed [8:0] speed_out,
   output logic signed [8:0] turn_out,
   output logic              motor_en_out,
   output logic [2:0]        state_out,
   output logic              fault_out
);
   localparam int unsigned ACQ_W  = $clog2(REACQ_FRAMES + 1);
   localparam int unsigned LOST_W = $clog2(LOST_FRAMES + 1);
   localparam int unsigned SRCH_W = $clog2(SEARCH_FRAMES + 1);
   localparam int unsigned WD_W   = $clog2(TIMEOUT_CYC + 1);

   localparam logic [ACQ_W-1:0]  ACQ_MAX  = ACQ_W'(REACQ_FRAMES);
   localparam logic [LOST_W-1:0] LOST_MAX = LOST_W'(LOST_FRAMES);
   localparam logic [SRCH_W-1:0] SRCH_MAX = SRCH_W'(SEARCH_FRAMES);
   localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT_CYC);
   localparam logic signed [9:0] RAMP_S   = 10'(RAMP_STEP);
   localparam logic signed [8:0] SRCH_TRN = 9'(SEARCH_TURN);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARMED  = 3'd1,
      ST_CHASE  = 3'd2,
      ST_SEARCH = 3'd3,
      ST_HALT   = 3'd4,
      ST_FAULT  = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [ACQ_W-1:0]    acq_q, acq_d;
   logic [LOST_W-1:0]   lost_q, lost_d;
   logic [SRCH_W-1:0]   search_q, search_d;
   logic [WD_W-1:0]     wdog_q, wdog_d;
   logic signed [8:0]   speed_q, speed_d, turn_q, turn_d;
   logic                motor_en_q, motor_en_d, fault_q, fault_d;
   logic                frame_prev_q, frame_prev_d;
   logic                frame_tick_c, valid_c, active_c, frozen_c;
   logic signed [8:0]   tgt_speed_c, tgt_turn_c;

   assign frame_tick_c = frame_done_in & ~frame_prev_q;
   assign valid_c      = (cur_rad_in >= 7'(MIN_RAD));

   // Move cur toward tgt by at most RAMP_STEP; -256 target clamps to -255.
   function automatic logic signed [8:0] ramp(input logic signed [8:0] cur,
                                              input logic signed [8:0] tgt);
      logic signed [9:0] t10, diff, r10;
      t10  = (tgt == -9'sd256) ? -10'sd255 : {tgt[8], tgt};
      diff = t10 - {cur[8], cur};
      if (diff > RAMP_S)       r10 = {cur[8], cur} + RAMP_S;
      else if (diff < -RAMP_S) r10 = {cur[8], cur} - RAMP_S;
      else                     r10 = t10;
      return r10[8:0];
   endfunction

   always_comb begin
      state_d      = state_q;
      acq_d        = acq_q;
      lost_d       = lost_q;
      search_d     = search_q;
      wdog_d       = '0;
      speed_d      = speed_q;
      turn_d       = turn_q;
      frame_prev_d = frame_done_in;
      active_c     = (state_q == ST_CHASE) || (state_q == ST_SEARCH);
      frozen_c     = active_c & pause_in;
      tgt_speed_c  = '0;
      tgt_turn_c   = '0;

      if (state_q == ST_CHASE && !pause_in) begin
         tgt_speed_c = speed_in;
         tgt_turn_c  = turn_in;
      end else if (state_q == ST_SEARCH && !pause_in) begin
         tgt_turn_c = SRCH_TRN;
      end

      case (state_q)
         ST_IDLE: begin
            acq_d    = '0;
            lost_d   = '0;
            search_d = '0;
            state_d  = ST_ARMED;
         end
         ST_ARMED: begin
            if (frame_tick_c) begin
               acq_d = !valid_c ? '0 : (acq_q == ACQ_MAX) ? acq_q : acq_q + 1'b1;
               if (acq_d == ACQ_MAX) begin
                  state_d = ST_CHASE;
                  acq_d   = '0;
                  lost_d  = '0;
               end
            end
         end
         ST_CHASE: begin
            if (frame_tick_c && !pause_in) begin
               lost_d = valid_c ? '0 : (lost_q == LOST_MAX) ? lost_q : lost_q + 1'b1;
               if (lost_d == LOST_MAX) begin
                  state_d  = ST_SEARCH;
                  search_d = '0;
                  acq_d    = '0;
               end
            end
         end
         ST_SEARCH: begin
            if (frame_tick_c && !pause_in) begin
               search_d = (search_q == SRCH_MAX) ? search_q : search_q + 1'b1;
               acq_d    = !valid_c ? '0 : (acq_q == ACQ_MAX) ? acq_q : acq_q + 1'b1;
               // Reacquisition wins over search expiry on the same frame.
               if (acq_d == ACQ_MAX) begin
                  state_d = ST_CHASE;
                  acq_d   = '0;
                  lost_d  = '0;
               end else if (search_d == SRCH_MAX) begin
                  state_d = ST_HALT;
               end
            end
         end
         default: begin
            acq_d    = '0;
            lost_d   = '0;
            search_d = '0;
         end
      endcase

      if (active_c && frame_tick_c) begin
         speed_d = ramp(speed_q, tgt_speed_c);
         turn_d  = ramp(turn_q, tgt_turn_c);
      end

      // Watchdog: a frame in the timeout cycle clears it before it can fire.
      if (state_q == ST_ARMED || active_c) begin
         if (frozen_c) begin
            wdog_d = wdog_q;
         end else if (!frame_tick_c) begin
            wdog_d = wdog_q + 1'b1;
            if (wdog_d == WD_MAX) state_d = ST_FAULT;
         end
      end

      if (!enable_in) begin
         state_d  = ST_IDLE;
         acq_d    = '0;
         lost_d   = '0;
         search_d = '0;
         wdog_d   = '0;
      end

      if (state_d != ST_CHASE && state_d != ST_SEARCH) begin
         speed_d = '0;
         turn_d  = '0;
      end
      motor_en_d = (state_d == ST_CHASE) || (state_d == ST_SEARCH);
      fault_d    = (state_d == ST_FAULT);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= ST_IDLE;
         acq_q        <= '0;
         lost_q       <= '0;
         search_q     <= '0;
         wdog_q       <= '0;
         speed_q      <= '0;
         turn_q       <= '0;
         motor_en_q   <= 1'b0;
         fault_q      <= 1'b0;
         frame_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         acq_q        <= acq_d;
         lost_q       <= lost_d;
         search_q     <= search_d;
         wdog_q       <= wdog_d;
         speed_q      <= speed_d;
         turn_q       <= turn_d;
         motor_en_q   <= motor_en_d;
         fault_q      <= fault_d;
         frame_prev_q <= frame_prev_d;
      end
   end

   assign speed_out    = speed_q;
   assign turn_out     = turn_q;
   assign motor_en_out = motor_en_q;
   assign state_out    = state_q;
   assign fault_out    = fault_q;
endmodule

// File: tb/tb_chase_supervisor.sv
// Testbench for chase_supervisor: directed scenarios plus randomized frames checked
// against a frame-level behavioural model.
module tb_chase_supervisor;
   localparam int TB_TIMEOUT = 200;

   logic              clk_in = 1'b0;
   logic              rst_in;
   logic              frame_done_in, enable_in, pause_in;
   logic [6:0]        cur_rad_in;
   logic signed [8:0] speed_in, turn_in, speed_out, turn_out;
   logic              motor_en_out, fault_out;
   logic [2:0]        state_out;

   int n_chk  = 0;
   int n_fail = 0;

   chase_supervisor #(.TIMEOUT_CYC(TB_TIMEOUT)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .frame_done_in(frame_done_in),
      .enable_in(enable_in), .pause_in(pause_in), .cur_rad_in(cur_rad_in),
      .speed_in(speed_in), .turn_in(turn_in), .speed_out(speed_out),
      .turn_out(turn_out), .motor_en_out(motor_en_out), .state_out(state_out),
      .fault_out(fault_out)
   );

   always #5 clk_in = ~clk_in;

   // Model: 0 idle, 1 armed, 2 chase, 3 search, 4 halt, 5 fault.
   int m_state, m_acq, m_lost, m_srch, m_wd, m_spd, m_trn;
   bit m_en, m_fault, m_fd;

   logic [22:0] dut_vec, exp_vec;
   assign dut_vec = {state_out, speed_out, turn_out, motor_en_out, fault_out};
   assign exp_vec = {3'(m_state), 9'(m_spd), 9'(m_trn), m_en, m_fault};

   function automatic int ramp_to(input int cur, input int tgt);
      int t;
      t = (tgt < -255) ? -255 : tgt;
      if (t - cur > 16) return cur + 16;
      if (cur - t > 16) return cur - 16;
      return t;
   endfunction

   task automatic model_step();
      bit tk, v, act, frz;
      int ns, ts, tt;
      if (rst_in) begin
         m_state = 0; m_acq = 0; m_lost = 0; m_srch = 0; m_wd = 0;
         m_spd = 0; m_trn = 0; m_en = 0; m_fault = 0; m_fd = 0;
         return;
      end
      tk   = frame_done_in && !m_fd;
      m_fd = frame_done_in;
      v    = (cur_rad_in >= 10);
      act  = (m_state == 2 || m_state == 3);
      frz  = act && pause_in;
      ns   = m_state;
      if (act && tk) begin
         ts = 0; tt = 0;
         if (!pause_in && m_state == 2) begin ts = int'(speed_in); tt = int'(turn_in); end
         if (!pause_in && m_state == 3) tt = 60;
         m_spd = ramp_to(m_spd, ts);
         m_trn = ramp_to(m_trn, tt);
      end
      if (m_state == 0) ns = 1;
      else if (m_state == 1 && tk) begin
         m_acq = v ? m_acq + 1 : 0;
         if (m_acq >= 3) begin ns = 2; m_acq = 0; m_lost = 0; end
      end else if (m_state == 2 && tk && !pause_in) begin
         m_lost = v ? 0 : m_lost + 1;
         if (m_lost >= 8) begin ns = 3; m_srch = 0; end
      end else if (m_state == 3 && tk && !pause_in) begin
         m_srch = m_srch + 1;
         m_acq  = v ? m_acq + 1 : 0;
         if (m_acq >= 3) begin ns = 2; m_acq = 0; m_lost = 0; end
         else if (m_srch >= 90) ns = 4;
      end
      if (m_state == 1 || act) begin
         if (!frz) begin
            if (tk) m_wd = 0;
            else begin
               m_wd = m_wd + 1;
               if (m_wd >= TB_TIMEOUT) ns = 5;
            end
         end
      end else m_wd = 0;
      if (!enable_in) begin ns = 0; m_acq = 0; m_lost = 0; m_srch = 0; m_wd = 0; end
      if (ns != 2 && ns != 3) begin m_spd = 0; m_trn = 0; end
      m_en    = (ns == 2 || ns == 3);
      m_fault = (ns == 5);
      m_state = ns;
   endtask

   initial forever begin
      @(posedge clk_in or posedge rst_in);
      model_step();
   end

   // One frame: strobe high for len cycles, then low for gap cycles; ends on a negedge.
   task automatic frame(input int rad, input int len, input int gap);
      @(negedge clk_in);
      cur_rad_in    = 7'(rad);
      frame_done_in = 1'b1;
      repeat (len) @(negedge clk_in);
      frame_done_in = 1'b0;
      repeat (gap) @(negedge clk_in);
   endtask

   task automatic test_reset();
      n_chk++;
      if (dut_vec !== 23'd0 || exp_vec !== 23'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %h expected 0 (model %h)", dut_vec, exp_vec);
      end
   endtask

   task automatic test_acquire();
      int exp_spd[7] = '{16, 32, 48, 64, 80, 96, 100};
      speed_in = 9'sd100; turn_in = '0;
      @(negedge clk_in); enable_in = 1'b1;
      @(negedge clk_in);
      n_chk++;
      if (state_out !== 3'd1) begin
         n_fail++; $display("FAIL armed_entry: state got %0d expected 1", state_out);
      end
      for (int i = 0; i < 3; i++) begin
         frame(12, 1, 0);
         n_chk++;
         if (state_out !== ((i == 2) ? 3'd2 : 3'd1) || dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL acquire_tick%0d: got %h expected %h", i, dut_vec, exp_vec);
         end
      end
      for (int i = 0; i < 7; i++) begin
         frame(12, 1, 1);
         n_chk++;
         if (speed_out !== 9'(exp_spd[i]) || motor_en_out !== 1'b1 || dut_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL ramp_up%0d: speed got %0d expected %0d en %b", i, speed_out, exp_spd[i], motor_en_out);
         end
      end
   endtask

   task automatic test_lost_and_search();
      int pat[6] = '{12, 12, 5, 12, 12, 12};
      for (int i = 0; i < 8; i++) frame(5, 1, 1);
      n_chk++;
      if (state_out !== 3'd3 || dut_vec !== exp_vec) begin
         n_fail++; $display("FAIL lost_to_search: got %h expected state 3 (%h)", dut_vec, exp_vec);
      end
      for (int i = 0; i < 6; i++) begin
         frame(pat[i], 1, 1);
         if (i == 0) begin
            n_chk++;
            if (turn_out !== 9'sd16) begin
               n_fail++; $display("FAIL search_turn_ramp: turn got %0d expected 16", turn_out);
            end
         end
         n_chk++;
         if (state_out !== ((i == 5) ? 3'd2 : 3'd3) || dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL reacquire_step%0d: got %h expected %h", i, dut_vec, exp_vec);
         end
      end
   endtask

   task automatic test_search_to_halt();
      for (int i = 0; i < 8; i++) frame(0, 1, 1);
      for (int i = 0; i < 89; i++) begin
         frame(0, 1, 0);
         n_chk++;
         if (state_out !== 3'd3 || dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL search_hold%0d: got %h expected %h", i, dut_vec, exp_vec);
         end
      end
      frame(0, 1, 0);
      n_chk++;
      if (dut_vec !== {3'd4, 20'd0}) begin
         n_fail++; $display("FAIL halt_entry: got %h expected %h", dut_vec, {3'd4, 20'd0});
      end
      enable_in = 1'b0;
      @(negedge clk_in);
      n_chk++;
      if (dut_vec !== 23'd0) begin
         n_fail++; $display("FAIL halt_to_idle: got %h expected 0", dut_vec);
      end
   endtask

   task automatic test_watchdog();
      for (int run = 0; run < 2; run++) begin
         enable_in = 1'b1;
         @(negedge clk_in);
         for (int i = 0; i < 3; i++) frame(12, 1, 0);
         repeat (TB_TIMEOUT - 1) @(negedge clk_in);
         n_chk++;
         if (state_out !== 3'd2) begin
            n_fail++; $display("FAIL wdog_pre%0d: state got %0d expected 2", run, state_out);
         end
         if (run == 1) frame_done_in = 1'b1;
         @(negedge clk_in);
         frame_done_in = 1'b0;
         n_chk++;
         if (run == 0 && (state_out !== 3'd5 || fault_out !== 1'b1 || motor_en_out !== 1'b0)) begin
            n_fail++; $display("FAIL wdog_fault: st %0d flt %b en %b expected 5 1 0", state_out, fault_out, motor_en_out);
         end else if (run == 1 && (state_out !== 3'd2 || fault_out !== 1'b0)) begin
            n_fail++; $display("FAIL wdog_tick_wins: st %0d flt %b expected 2 0", state_out, fault_out);
         end
         enable_in = 1'b0;
         @(negedge clk_in);
         n_chk++;
         if (fault_out !== 1'b0 || state_out !== 3'd0) begin
            n_fail++; $display("FAIL wdog_clear%0d: st %0d flt %b expected 0 0", run, state_out, fault_out);
         end
      end
   endtask

   task automatic test_edge_and_pause();
      int exp_p[3] = '{24, 8, 0};
      speed_in = 9'sd40; turn_in = '0;
      enable_in = 1'b1;
      @(negedge clk_in);
      frame(12, 4, 1);
      n_chk++;
      if (state_out !== 3'd1) begin
         n_fail++; $display("FAIL single_tick: state got %0d expected 1", state_out);
      end
      frame(12, 1, 1); frame(12, 1, 1);
      for (int i = 0; i < 3; i++) frame(12, 2, 1);
      n_chk++;
      if (state_out !== 3'd2 || speed_out !== 9'sd40) begin
         n_fail++; $display("FAIL pre_pause: st %0d speed %0d expected 2 40", state_out, speed_out);
      end
      pause_in = 1'b1;
      for (int i = 0; i < 9; i++) begin
         frame(0, 1, 1);
         n_chk++;
         if (state_out !== 3'd2 || (i < 3 && speed_out !== 9'(exp_p[i])) || dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL pause%0d: got %h expected %h", i, dut_vec, exp_vec);
         end
      end
      pause_in = 1'b0;
   endtask

   task automatic test_reset_mid_chase();
      speed_in = 9'sd80;
      for (int i = 0; i < 5; i++) frame(12, 1, 1);
      n_chk++;
      if (speed_out !== 9'sd80 || state_out !== 3'd2) begin
         n_fail++; $display("FAIL pre_reset: speed %0d st %0d expected 80 2", speed_out, state_out);
      end
      #2 rst_in = 1'b1;
      #1;
      n_chk++;
      if (dut_vec !== 23'd0) begin
         n_fail++; $display("FAIL async_reset: got %h expected 0", dut_vec);
      end
      @(negedge clk_in); rst_in = 1'b0;
   endtask

   task automatic test_random();
      int gap;
      for (int i = 0; i < 300; i++) begin
         enable_in = ($urandom_range(0, 29) != 0);
         pause_in  = ($urandom_range(0, 5) == 0);
         speed_in  = 9'($urandom);
         turn_in   = 9'($urandom);
         gap = ($urandom_range(0, 19) == 0) ? int'($urandom_range(150, 260)) : int'($urandom_range(0, 4));
         frame(int'($urandom_range(0, 20)), int'($urandom_range(1, 4)), gap);
         n_chk++;
         if (dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL random%0d: got %h expected %h", i, dut_vec, exp_vec);
         end
      end
   endtask

   initial begin
      rst_in = 1'b1; frame_done_in = 1'b0; enable_in = 1'b0; pause_in = 1'b0;
      cur_rad_in = '0; speed_in = '0; turn_in = '0;
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      @(negedge clk_in);
      test_reset();
      test_acquire();
      test_lost_and_search();
      test_search_to_halt();
      test_watchdog();
      test_edge_and_pause();
      test_reset_mid_chase();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/chase_supervisor.md
Name: chase_supervisor

Overview:
- Run-time supervisor between the tracker/control loop and motor_out.
- Sequences the chase: arm, acquire target, chase, search when lost, halt. Ramps speed/turn commands once per camera frame, gates motor enable.
- Watchdog forces a safe stop if camera frames stop arriving.
- Inputs are the control block's speed/turn plus per-frame tracker radius; outputs feed motor_out and the 7-segment debug mux.

Parameters:
MIN_RAD, 10, tracked radius at or above this counts as a valid target frame
REACQ_FRAMES, 3, consecutive valid frames needed to enter CHASE
LOST_FRAMES, 8, consecutive invalid frames in CHASE before SEARCH
SEARCH_FRAMES, 90, frames spent in SEARCH before HALT
SEARCH_TURN, 60, signed turn command used while searching
RAMP_STEP, 16, maximum change of speed_out/turn_out per frame
TIMEOUT_CYC, 4333333, clk_in cycles without a frame before FAULT (~2 frames at 65 MHz)

Ports:
clk_in  input  1  system clock (65 MHz)
rst_in  input  1  reset; asynchronous, active-high
frame_done_in  input  1  end-of-frame strobe from camera_read; may stay high several clk_in cycles
enable_in  input  1  move permission from initialize
pause_in  input  1  operator pause
cur_rad_in  input  7  tracked radius for the latest frame
speed_in  input  9  signed speed request from control
turn_in  input  9  signed turn request from control
speed_out  output  9  signed ramped speed to motor_out
turn_out  output  9  signed ramped turn to motor_out
motor_en_out  output  1  motor enable; gates jc drive
state_out  output  3  encoded state for display
fault_out  output  1  sticky watchdog fault flag

Behaviour:
- Reset (async, active-high):
  - state=IDLE(0); all counters 0.
  - speed_out=0, turn_out=0, motor_en_out=0, fault_out=0.
  - Previous-frame register cleared.
- Frame tick: frame_tick = frame_done_in & ~frame_d (frame_d is last cycle's frame_done_in). Exactly one tick per rising edge. All per-frame actions happen on the clock edge where frame_tick=1; results are visible the next cycle.
- valid = (cur_rad_in >= MIN_RAD), sampled only on frame_tick.
- States (state_out encoding in parentheses): IDLE(0), ARMED(1), CHASE(2), SEARCH(3), HALT(4), FAULT(5).
- Global rule: enable_in=0 forces IDLE next cycle from any state. It clears fault_out and all counters, and forces outputs to 0. This has highest priority.
- IDLE: enable_in=1 -> ARMED.
- ARMED:
  - Valid ticks increment acq_cnt; an invalid tick clears it.
  - acq_cnt reaching REACQ_FRAMES -> CHASE, with acq_cnt and lost_cnt cleared.
- CHASE:
  - Target = (speed_in, turn_in).
  - An invalid tick increments lost_cnt; a valid tick clears it.
  - lost_cnt reaching LOST_FRAMES -> SEARCH, with search_cnt cleared.
- SEARCH:
  - Target = (0, SEARCH_TURN).
  - Every tick increments search_cnt. Valid ticks increment acq_cnt; invalid ticks clear it.
  - acq_cnt reaching REACQ_FRAMES -> CHASE. This takes priority over search_cnt reaching SEARCH_FRAMES -> HALT on the same tick.
- HALT / FAULT: outputs 0, motor_en_out=0; they exit only via enable_in=0. FAULT sets fault_out=1.
- motor_en_out = 1 only in CHASE/SEARCH, registered with the state.
- Outside CHASE/SEARCH, speed_out and turn_out are forced to 0 immediately (hard stop, no ramp).
- Ramp, on each tick in CHASE/SEARCH, applied per output:
  - diff = target - out, computed in 10-bit signed.
  - |diff| <= RAMP_STEP -> out = target; otherwise out moves RAMP_STEP toward target.
  - Results stay within -255..255; a target of -256 is clamped to -255.
- Pause: pause_in=1 in CHASE/SEARCH sets the target to (0,0), which is still ramped. acq/lost/search counters and the watchdog are frozen; state is held. On release, counting resumes from the frozen values.
- Watchdog:
  - Counts clk_in cycles in ARMED/CHASE/SEARCH; cleared by frame_tick and in all other states.
  - Reaching TIMEOUT_CYC -> FAULT.
  - A frame_tick in the same cycle wins: counter cleared, no fault.
- Counters saturate at their terminal values and never wrap.

Test Plan:
1. Reset mid-CHASE with speed_out=80 -> same cycle all outputs 0, state_out=0, fault_out=0.
2. enable_in=1; three ticks with rad=12; speed_in=100 -> CHASE after the 3rd tick. speed_out then steps 16,32,48,64,80,96,100 on successive ticks; motor_en_out=1.
3. In CHASE, 8 ticks with rad=5 -> SEARCH, turn_out ramps toward 60. A tick pattern of 2 valid, 1 invalid, 3 valid -> CHASE only after the last of the 3 consecutive valid ticks.
4. In SEARCH with rad=0 for 90 ticks -> HALT, outputs 0; enable_in=0 -> IDLE next cycle.
5. In CHASE, no frame_done_in for TIMEOUT_CYC cycles -> FAULT, fault_out=1, motor_en_out=0. A repeat run with a tick on exactly cycle TIMEOUT_CYC stays in CHASE.
6. frame_done_in held high 4 cycles -> exactly one tick. pause_in=1 with speed_out=40 -> 24,8,0 on successive ticks, state stays CHASE.
